// File: rtl/mux16_rr_arbiter.sv
// 16:1 round-robin arbiter and one-bit data mux with a registered grant/handshake.
// Define MUX16_ARB_TIMEOUT_EN to drop grants that wait TMO_CYCLES without out_ready.
module mux16_rr_arbiter #(
  parameter int unsigned TMO_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic [15:0] data_in,
  input  logic        out_ready,
  output logic [3:0]  sel,
  output logic [15:0] gnt,
  output logic        data_out,
  output logic        out_valid,
  output logic        timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [3:0] last;
  logic [3:0] win;
  logic [3:0] idx;
  logic       found;
  logic       expire;

  if (TMO_CYCLES < 2 || TMO_CYCLES > 255) begin : g_bad_tmo
    $error("TMO_CYCLES must be in 2..255");
  end

  // Search starts one past the previous winner; i = 16 wraps back to last itself.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= 16; i++) begin
      idx = last + 4'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

`ifdef MUX16_ARB_TIMEOUT_EN
  logic [7:0] wait_cnt;

  assign expire = !out_ready && (wait_cnt == 8'(TMO_CYCLES - 1));

  // Counter is held at zero outside GRANT, so it is cleared on every grant entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= (state == GRANT) && expire;
      if (state != GRANT)
        wait_cnt <= '0;
      else if (!out_ready)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 4'hF;
      sel       <= '0;
      gnt       <= '0;
      data_out  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            sel       <= win;
            gnt       <= 16'd1 << win;
            data_out  <= data_in[win];
            out_valid <= 1'b1;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (out_ready || expire) begin
            last      <= sel;
            gnt       <= '0;
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Scoreboard bench for mux16_rr_arbiter: a transaction-level model predicts each
// cycle's outputs into a queue, and a negedge monitor pops and compares them.
module tb_mux16_rr_arbiter;

  localparam int unsigned TMO = 4;
`ifdef MUX16_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic [15:0] data_in;
  logic        out_ready;
  logic [3:0]  sel;
  logic [15:0] gnt;
  logic        data_out;
  logic        out_valid;
  logic        timeout;

  mux16_rr_arbiter #(.TMO_CYCLES(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data_in   (data_in),
    .out_ready (out_ready),
    .sel       (sel),
    .gnt       (gnt),
    .data_out  (data_out),
    .out_valid (out_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  sel;
    logic [15:0] gnt;
    logic        dout;
    logic        valid;
    logic        tmo;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: who owns the grant, how long it has waited, and the pointer.
  bit   m_busy;
  int   m_owner;
  int   m_ptr;
  int   m_waited;
  bit   m_dout;
  bit   m_tmo;

  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      m_busy = 0; m_owner = 0; m_ptr = 15; m_waited = 0; m_dout = 0; m_tmo = 0;
    end else begin
      m_tmo = 0;
      if (m_busy) begin
        if (out_ready) begin
          m_busy = 0; m_ptr = m_owner;
        end else if (TMO_EN && m_waited == int'(TMO) - 1) begin
          m_busy = 0; m_ptr = m_owner; m_tmo = 1;
        end else begin
          m_waited++;
        end
      end else if (req != 16'h0) begin
        for (int k = 1; k <= 16; k++) begin
          if (!m_busy && req[(m_ptr + k) % 16]) begin
            m_owner  = (m_ptr + k) % 16;
            m_busy   = 1;
            m_waited = 0;
            m_dout   = data_in[m_owner];
          end
        end
      end
    end
    e.sel   = 4'(m_owner);
    e.gnt   = m_busy ? (16'd1 << m_owner) : 16'h0;
    e.dout  = m_dout;
    e.valid = m_busy;
    e.tmo   = m_tmo;
    exp_q.push_back(e);
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
    end else begin
      e = exp_q.pop_front();
      chk("sel",       16'(sel),       16'(e.sel));
      chk("gnt",       gnt,            e.gnt);
      chk("data_out",  16'(data_out),  16'(e.dout));
      chk("out_valid", 16'(out_valid), 16'(e.valid));
      chk("timeout",   16'(timeout),   16'(e.tmo));
      chk("gnt_onehot_sel", 16'($onehot0(gnt) && (!out_valid || gnt[sel])), 16'd1);
    end
  end

  task automatic step(input logic r, input logic [15:0] q, input logic [15:0] d,
                      input logic rdy, input int n);
    for (int i = 0; i < n; i++) begin
      rst = r; req = q; data_in = d; out_ready = rdy;
      @(negedge clk);
    end
  endtask

  initial begin
    step(1'b1, 16'h0000, 16'h0000, 1'b0, 2);
    // single requester, granted every two cycles
    step(1'b0, 16'h0001, 16'h0001, 1'b1, 6);
    // all requesting: full rotation and wrap
    for (int i = 0; i < 36; i++) step(1'b0, 16'hFFFF, 16'($urandom), 1'b1, 1);
    step(1'b0, 16'h8001, 16'hFFFF, 1'b1, 8);
    // grant to 5, inputs toggled while out_ready is low
    step(1'b0, 16'h0000, 16'h0000, 1'b1, 2);
    step(1'b1, 16'h0000, 16'h0000, 1'b0, 1);
    step(1'b0, 16'h0020, 16'h0020, 1'b0, 1);
    step(1'b0, 16'h0000, 16'h0000, 1'b0, 1);
    step(1'b0, 16'hFFDF, 16'hFFDF, 1'b0, 1);
    step(1'b0, 16'h0020, 16'h0020, 1'b0, 1);
    step(1'b0, 16'h0020, 16'h0000, 1'b1, 2);
    // reset in the middle of a grant on index 9
    step(1'b0, 16'h0200, 16'h0200, 1'b0, 3);
    step(1'b1, 16'h0200, 16'h0200, 1'b0, 1);
    step(1'b0, 16'hFFFF, 16'h0000, 1'b1, 5);
    // long stall on two requesters (times out only when enabled)
    step(1'b0, 16'h0024, 16'h0004, 1'b0, 14);
    step(1'b0, 16'h0024, 16'h0020, 1'b1, 4);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] r;
      r = ($urandom_range(0, 3) == 0) ? 16'($urandom) : (16'd1 << $urandom_range(0, 15)) |
          (16'd1 << $urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) r = 16'h0;
      step(($urandom_range(0, 199) == 0), r, 16'($urandom), ($urandom_range(0, 9) < 6), 1);
    end
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
